// File: rtl/force_release_ctl.sv
// Override controller: holds a captured value on net_out until release (or timeout),
// then hands the net back to net_in. Optional auto-release counter under `FORCE_TIMEOUT_EN.
module force_release_ctl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] net_in,
   input  logic             force_req,
   input  logic [WIDTH-1:0] force_val,
   input  logic [CNT_W-1:0] force_cycles,
   input  logic             release_req,
   output logic [WIDTH-1:0] net_out,
   output logic             forced,
   output logic             force_ack,
   output logic             release_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FORCED  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             ack_d;

`ifdef FORCE_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;

   assign timeout = (cnt_q == CNT_W'(1));
`else
   logic             unused_cycles;

   assign unused_cycles = ^force_cycles;
`endif

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      ack_d   = 1'b0;
`ifdef FORCE_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (force_req) begin
               state_d = FORCED;
               hold_d  = force_val;
               ack_d   = 1'b1;
`ifdef FORCE_TIMEOUT_EN
               cnt_d   = force_cycles;
`endif
            end
         end
         FORCED: begin
            // Release beats a re-force; a re-force beats a timeout.
            if (release_req) begin
               state_d = RELEASE;
            end else if (force_req) begin
               hold_d  = force_val;
               ack_d   = 1'b1;
`ifdef FORCE_TIMEOUT_EN
               cnt_d   = force_cycles;
`endif
            end else begin
`ifdef FORCE_TIMEOUT_EN
               if (timeout) state_d = RELEASE;
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
`endif
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         // NOTE: hold_q is reset too, so no stale override value survives a reset.
         hold_q    <= '0;
         force_ack <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         force_ack <= ack_d;
      end
   end

`ifdef FORCE_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`endif

   assign forced       = (state_q == FORCED);
   assign release_done = (state_q == RELEASE);
   assign net_out      = forced ? hold_q : net_in;

endmodule

// File: tb/tb_force_release_ctl.sv
// Scoreboard bench for force_release_ctl: directed test-plan sequences plus random traffic,
// checked against a remaining-cycles reference model. Honours `FORCE_TIMEOUT_EN like the RTL.
module tb_force_release_ctl;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

`ifdef FORCE_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] net_in;
   logic             force_req;
   logic [WIDTH-1:0] force_val;
   logic [CNT_W-1:0] force_cycles;
   logic             release_req;
   logic [WIDTH-1:0] net_out;
   logic             forced;
   logic             force_ack;
   logic             release_done;

   force_release_ctl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .net_in      (net_in),
      .force_req   (force_req),
      .force_val   (force_val),
      .force_cycles(force_cycles),
      .release_req (release_req),
      .net_out     (net_out),
      .forced      (forced),
      .force_ack   (force_ack),
      .release_done(release_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] out;
      logic             frc;
      logic             ack;
      logic             done;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: "holding" plus cycles left before auto-release (0 = indefinite).
   bit               m_holding;
   bit               m_releasing;
   logic [WIDTH-1:0] m_value;
   int               m_left;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_holding   = 1'b0;
      m_releasing = 1'b0;
      m_value     = '0;
      m_left      = 0;
   endtask

   // One clock cycle: apply inputs, advance the model across the coming edge, queue expectation.
   task automatic step(input bit fr, input logic [WIDTH-1:0] fv, input int fc,
                       input bit rr, input logic [WIDTH-1:0] ni);
      exp_t e;
      bit   acked;
      @(negedge clk);
      force_req    = fr;
      force_val    = fv;
      force_cycles = CNT_W'(fc);
      release_req  = rr;
      net_in       = ni;
      acked = 1'b0;
      if (m_releasing) begin
         m_releasing = 1'b0;
      end else if (!m_holding) begin
         if (fr) begin
            m_holding = 1'b1; m_value = fv; acked = 1'b1;
            m_left = TIMEOUT_EN ? fc : 0;
         end
      end else if (rr) begin
         m_holding = 1'b0; m_releasing = 1'b1;
      end else if (fr) begin
         m_value = fv; acked = 1'b1;
         m_left = TIMEOUT_EN ? fc : 0;
      end else if (m_left == 1) begin
         m_holding = 1'b0; m_releasing = 1'b1; m_left = 0;
      end else if (m_left > 1) begin
         m_left--;
      end
      e.out  = m_holding ? m_value : ni;
      e.frc  = m_holding;
      e.ack  = acked;
      e.done = m_releasing;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input logic [WIDTH-1:0] ni);
      for (int i = 0; i < n; i++) step(1'b0, '0, 0, 1'b0, ni);
   endtask

   // Mid-cycle change of net_in: visible at once unless the net is forced.
   task automatic poke(input logic [WIDTH-1:0] ni);
      @(posedge clk);
      #3;
      net_in = ni;
      #1;
      check("comb_net_out", 32'(net_out), 32'(m_holding ? m_value : ni));
   endtask

   task automatic async_reset(input logic [WIDTH-1:0] ni);
      @(posedge clk);
      #3;
      force_req = 1'b0; release_req = 1'b0; net_in = ni;
      reset = 1'b1;
      #1;
      check("rst_forced", 32'(forced), 32'd0);
      check("rst_net_out", 32'(net_out), 32'(ni));
      check("rst_ack", 32'(force_ack), 32'd0);
      check("rst_done", 32'(release_done), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Monitor: pops one expectation per cycle, sampled away from the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("net_out", 32'(net_out), 32'(e.out));
            check("forced", 32'(forced), 32'(e.frc));
            check("force_ack", 32'(force_ack), 32'(e.ack));
            check("release_done", 32'(release_done), 32'(e.done));
         end
      end
   end

   initial begin
      reset = 1'b1; net_in = 4'h5; force_req = 1'b0; force_val = '0;
      force_cycles = '0; release_req = 1'b0;
      model_reset();
      #1;
      check("init_forced", 32'(forced), 32'd0);
      check("init_net_out", 32'(net_out), 32'h5);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Basic force and release, with net_in moving while forced.
      step(1'b1, 4'hA, 0, 1'b0, 4'h5);
      idle(20, 4'h5);
      poke(4'h3);
      idle(2, 4'h3);
      step(1'b0, '0, 0, 1'b1, 4'h3);
      idle(2, 4'h3);
      poke(4'h9);

      // Timeout of 3 cycles (persists in the build without the counter).
      step(1'b1, 4'hF, 3, 1'b0, 4'h9);
      idle(10, 4'h9);
      step(1'b0, '0, 0, 1'b1, 4'h9);
      idle(2, 4'h9);

      // Release and force together: release first, request acked from IDLE.
      step(1'b1, 4'hA, 0, 1'b0, 4'h1);
      step(1'b0, '0, 0, 1'b0, 4'h1);
      step(1'b1, 4'h7, 0, 1'b1, 4'h1);
      step(1'b1, 4'h7, 0, 1'b0, 4'h1);
      step(1'b1, 4'h7, 0, 1'b0, 4'h1);
      idle(3, 4'h1);

      // Re-force with a reloaded count, then a timeout racing a release.
      step(1'b1, 4'h2, 5, 1'b0, 4'h1);
      idle(3, 4'h1);
      step(1'b0, '0, 0, 1'b1, 4'h1);
      idle(2, 4'h1);
      step(1'b1, 4'hC, 2, 1'b0, 4'h6);
      step(1'b0, '0, 0, 1'b0, 4'h6);
      step(1'b0, '0, 0, 1'b1, 4'h6);
      idle(2, 4'h6);

      // Timeout racing a re-force: re-force wins and the count restarts.
      step(1'b1, 4'h4, 2, 1'b0, 4'h6);
      step(1'b0, '0, 0, 1'b0, 4'h6);
      step(1'b1, 4'hB, 2, 1'b0, 4'h6);
      idle(4, 4'h6);

      // Asynchronous reset in the middle of a force, then a normal force.
      step(1'b1, 4'hE, 0, 1'b0, 4'h8);
      idle(3, 4'h8);
      async_reset(4'h8);
      step(1'b1, 4'hD, 1, 1'b0, 4'h8);
      idle(3, 4'h8);
      step(1'b0, '0, 0, 1'b1, 4'h8);
      idle(2, 4'h8);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) < 20, WIDTH'($urandom), int'($urandom_range(0, 6)),
              $urandom_range(0, 99) < 12, WIDTH'($urandom));
         if ($urandom_range(0, 99) < 5) poke(WIDTH'($urandom));
         if (i == 300) async_reset(WIDTH'($urandom));
      end
      idle(3, 4'h0);

      @(posedge clk);
      #4;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
